// File: rtl/key_filter_bank_pkg.sv
// Shared definitions for the key debounce bank: per-channel FSM state
// encoding and the counter-width helper used to size filter/hold counters.
package key_filter_bank_pkg;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_FILT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_FILT = 2'd3;

    // One spare bit above $clog2 so the terminal count itself is representable.
    function automatic int cnt_width(input int value);
        return $clog2(value) + 1;
    endfunction

endpackage

// File: rtl/key_filter_bank_ch.sv
// One debounced key channel: 2-flop synchronizer, 4-state accept FSM,
// filter counter for level changes and saturating hold counter for long press.
module key_filter_ch
    import key_filter_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_value,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int FW = cnt_width(DEBOUNCE_CYC);
    localparam int HW = cnt_width(LONG_CYC);

    localparam logic [FW-1:0] FILT_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0] FILT_ONE  = {{(FW-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0] FILT_LAST = FW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_ONE  = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] filt_q,  filt_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic          value_q, value_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q,  long_d;
    logic          pin_low_s;

    // Synchronizer next-state: key pin is asynchronous to sys_clk.
    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
    end

    assign pin_low_s = ~sync2_q;

    // Accept FSM, filter counter and hold counter next-state.
    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        hold_d    = hold_q;
        value_d   = value_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                value_d = 1'b0;
                hold_d  = HOLD_ZERO;
                if (pin_low_s) begin
                    state_d = ST_PRESS_FILT;
                    filt_d  = FILT_ONE;
                end else begin
                    filt_d  = FILT_ZERO;
                end
            end
            ST_PRESS_FILT: begin
                if (!pin_low_s) begin
                    state_d = ST_RELEASED;
                    filt_d  = FILT_ZERO;
                end else if (filt_q == FILT_LAST) begin
                    state_d = ST_PRESSED;
                    filt_d  = FILT_ZERO;
                    hold_d  = HOLD_ZERO;
                    value_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    filt_d  = filt_q + FILT_ONE;
                end
            end
            ST_PRESSED: begin
                // Hold counter saturates at LONG_CYC so key_long cannot repeat.
                if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + HOLD_ONE;
                    long_d = (hold_q == HOLD_LAST);
                end else begin
                    hold_d = hold_q;
                end
                if (!pin_low_s) begin
                    state_d = ST_RELEASE_FILT;
                    filt_d  = FILT_ONE;
                end else begin
                    filt_d  = FILT_ZERO;
                end
            end
            ST_RELEASE_FILT: begin
                if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + HOLD_ONE;
                    long_d = (hold_q == HOLD_LAST);
                end else begin
                    hold_d = hold_q;
                end
                if (pin_low_s) begin
                    state_d = ST_PRESSED;
                    filt_d  = FILT_ZERO;
                end else if (filt_q == FILT_LAST) begin
                    state_d   = ST_RELEASED;
                    filt_d    = FILT_ZERO;
                    hold_d    = HOLD_ZERO;
                    value_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    filt_d    = filt_q + FILT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                filt_d  = FILT_ZERO;
                hold_d  = HOLD_ZERO;
                value_d = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronizer resets to released (1).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_RELEASED;
            filt_q    <= FILT_ZERO;
            hold_q    <= HOLD_ZERO;
            value_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            filt_q    <= filt_d;
            hold_q    <= hold_d;
            value_q   <= value_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign key_value   = value_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_filter_bank.sv
// Bank of KEY_NUM independent debounced key channels for active-low board keys.
module key_filter_bank
    import key_filter_bank_pkg::*;
#(
    parameter int KEY_NUM      = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_value,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_in      (key[i]),
            .key_value   (key_value[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_filter_bank.sv
// Directed bench for key_filter_bank with DEBOUNCE_CYC=8, LONG_CYC=32.
module tb_key_filter_bank;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key;
    logic [3:0] key_value;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int checks = 0;
    int errors = 0;

    key_filter_bank #(
        .KEY_NUM      (4),
        .DEBOUNCE_CYC (8),
        .LONG_CYC     (32)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key         (key),
        .key_value   (key_value),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ev, input logic [3:0] ep,
                           input logic [3:0] er, input logic [3:0] el);
        chk({tag, ".value"},   key_value,   ev);
        chk({tag, ".press"},   key_press,   ep);
        chk({tag, ".release"}, key_release, er);
        chk({tag, ".long"},    key_long,    el);
    endtask

    initial begin
        int lvl [4];
        int len [4];
        lvl = '{0, 1, 0, 1};
        len = '{3, 2, 5, 12};

        // Reset, all keys released
        sys_rst_n = 1'b0;
        key       = 4'hF;
        tick(3);
        chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            chk_all("idle", 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // key[0] press: key_press at edge 10, key_long 32 cycles later, once
        key = 4'b1110;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            chk_all("k0_filt", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        tick(1);
        chk_all("k0_press", 4'b0001, 4'b0001, 4'h0, 4'h0);
        for (int c = 0; c < 31; c++) begin
            tick(1);
            chk_all("k0_hold", 4'b0001, 4'h0, 4'h0, 4'h0);
        end
        tick(1);
        chk_all("k0_long", 4'b0001, 4'h0, 4'h0, 4'b0001);
        for (int c = 0; c < 100; c++) begin
            tick(1);
            chk_all("k0_norepeat", 4'b0001, 4'h0, 4'h0, 4'h0);
        end

        // key[1] bounce: no events, key_value[1] stays 0
        for (int s = 0; s < 4; s++) begin
            key[1] = lvl[s][0];
            for (int c = 0; c < len[s]; c++) begin
                tick(1);
                chk_all("k1_bounce", 4'b0001, 4'h0, 4'h0, 4'h0);
            end
        end
        key[1] = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            chk_all("k1_filt", 4'b0001, 4'h0, 4'h0, 4'h0);
        end
        tick(1);
        chk_all("k1_press", 4'b0011, 4'b0010, 4'h0, 4'h0);

        // Release keys 0 and 1 together
        key = 4'hF;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            chk_all("k01_rfilt", 4'b0011, 4'h0, 4'h0, 4'h0);
        end
        tick(1);
        chk_all("k01_release", 4'h0, 4'h0, 4'b0011, 4'h0);
        tick(1);
        chk_all("k01_idle", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(4);

        // key[2] short press: release after 20 accepted cycles, no long
        key = 4'b1011;
        tick(9);
        chk_all("k2_filt", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("k2_press", 4'b0100, 4'b0100, 4'h0, 4'h0);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk_all("k2_hold", 4'b0100, 4'h0, 4'h0, 4'h0);
        end
        key = 4'hF;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            chk_all("k2_rfilt", 4'b0100, 4'h0, 4'h0, 4'h0);
        end
        tick(1);
        chk_all("k2_release", 4'h0, 4'h0, 4'b0100, 4'h0);
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk_all("k2_nolong", 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // key[0] and key[3] together, then a 4-cycle glitch on key[3]
        key = 4'b0110;
        tick(9);
        chk_all("k03_filt", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("k03_press", 4'b1001, 4'b1001, 4'h0, 4'h0);
        tick(1);
        chk_all("k03_after", 4'b1001, 4'h0, 4'h0, 4'h0);
        key = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk_all("k3_glitch", 4'b1001, 4'h0, 4'h0, 4'h0);
        end
        key = 4'b0110;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk_all("k3_noglitch", 4'b1001, 4'h0, 4'h0, 4'h0);
        end
        key = 4'hF;
        tick(9);
        chk_all("k03_rfilt", 4'b1001, 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("k03_release", 4'h0, 4'h0, 4'b1001, 4'h0);
        tick(5);

        // key[1] held through a reset pulse
        key = 4'b1101;
        tick(10);
        chk_all("k1b_press", 4'b0010, 4'b0010, 4'h0, 4'h0);
        tick(5);
        sys_rst_n = 1'b0;
        #1;
        chk_all("k1b_async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(2);
        chk_all("k1b_in_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            chk_all("k1b_refilt", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        tick(1);
        chk_all("k1b_repress", 4'b0010, 4'b0010, 4'h0, 4'h0);
        tick(1);
        chk_all("k1b_after", 4'b0010, 4'h0, 4'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_filter_bank.md
# key_filter_bank

Debounced push-button reader for the board's active-low keys. It is the input-side counterpart to the LED drivers: it samples the raw key pins, filters contact bounce and publishes a stable pressed level plus single-cycle press, release and long-press events. Downstream LED and pattern logic consumes these events instead of raw pins.

## Interface
Parameters:
- KEY_NUM, 4, number of independent key channels.
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); minimum 2.
- LONG_CYC, 50_000_000, cycles a key stays accepted-pressed before key_long fires (1 s at 50 MHz); must exceed DEBOUNCE_CYC.

Ports:
- sys_clk  input  1  system clock; the block's only clock.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key  input  KEY_NUM  raw key pins, active-low (0 = pressed), asynchronous to sys_clk.
- key_value  output  KEY_NUM  debounced level, 1 = pressed.
- key_press  output  KEY_NUM  one-cycle pulse when a press is accepted.
- key_release  output  KEY_NUM  one-cycle pulse when a release is accepted.
- key_long  output  KEY_NUM  one-cycle pulse, at most once per press, after LONG_CYC held cycles.

## Operation
- Channels are fully independent; channel i uses only key[i].
- Each key[i] passes through a 2-flop synchronizer; both flops reset to 1 (released).
- Per-channel FSM with 4 states:
  - RELEASED: key_value=0. Synchronized pin = 0 -> PRESS_FILT with the filter counter at 1.
  - PRESS_FILT: pin = 1 -> RELEASED, counter cleared. Pin = 0 and counter == DEBOUNCE_CYC-1 -> PRESSED, pulse key_press. Otherwise the counter increments.
  - PRESSED: key_value=1, the hold counter increments each cycle. On the cycle it reaches LONG_CYC, pulse key_long and saturate, so there is no repeat. Pin = 1 -> RELEASE_FILT with the filter counter at 1. The hold counter keeps running through RELEASE_FILT.
  - RELEASE_FILT: key_value stays 1. Pin = 0 -> PRESSED, filter counter cleared. Pin = 1 and counter == DEBOUNCE_CYC-1 -> RELEASED, pulse key_release, clear the hold counter.
- A glitch shorter than DEBOUNCE_CYC cycles produces no event and no key_value change.
- A long press still produces key_release on release. A release before LONG_CYC produces no key_long.
- Counter widths are $clog2 of the parameter + 1. Counters never wrap: the filter counter clears on every state exit, and the hold counter saturates at LONG_CYC.

## Timing
- Reset values: key_value=0, key_press=0, key_release=0, key_long=0, all FSMs in RELEASED, all counters 0.
- All outputs are registered.
- Press latency: 2 synchronizer cycles + DEBOUNCE_CYC cycles from a clean pin edge to key_press high. key_value rises on the same edge that key_press rises.
- Release latency is identical; key_value falls together with the key_release pulse.
- key_long rises exactly LONG_CYC cycles after key_press rose, provided there is no accepted release before then.
- key_press and key_long never coincide on the same channel. Different channels may pulse on the same cycle.
- Reset asserted mid-filter or mid-hold: all outputs return to 0 immediately and no pulse is emitted. A key held through reset release needs a full debounce before key_press fires.

## Structure
- Shared package holds: the FSM state encoding (RELEASED, PRESS_FILT, PRESSED, RELEASE_FILT) and the counter-width helper function.
- Sub-module key_filter_ch: synchronizer + FSM + both counters for one channel.
- The top level is a generate loop of KEY_NUM key_filter_ch instances.

## Test plan
Use DEBOUNCE_CYC=8, LONG_CYC=32, KEY_NUM=4.
- Reset release with all keys high -> all outputs 0 for 100 cycles.
- key[0] low and held -> key_press[0] pulses 1 cycle at cycle 10 after the edge, and key_value[0]=1 from then on. Hold 32 more cycles -> key_long[0] pulses once, with no repeat over a further 100 cycles.
- key[1] bounces (low 3 cycles, high 2, low 5, high) -> no pulses and key_value[1] stays 0. Then key[1] held low -> key_press[1] fires 10 cycles after the last falling edge.
- key[2] pressed, then released after 20 accepted cycles -> key_release[2] fires 10 cycles after the rising edge, with no key_long[2].
- key[0] and key[3] pressed on the same cycle -> both key_press bits pulse on the same cycle. A 4-cycle high glitch on key[3] while PRESSED -> no key_release[3].
- sys_rst_n pulsed low while key[1] is in PRESSED and still held -> outputs 0 at once. After reset release, key_press[1] fires 10 cycles later with no key_release[1].
